// File: rtl/dhcp_client_deadlock_scan_ctrl.sv
// ----------------------------------------------------------------------------
// dhcp_client_deadlock_scan_ctrl
//
// Supervises the per-process deadlock monitors of the dhcp_client HLS dataflow
// region. The block-flag inputs are scanned round-robin. A raised flag becomes
// a candidate, and it must stay high for HOLD_CYCLES consecutive samples before
// it is confirmed. A confirmed deadlock is latched as a sticky report. The
// report carries the monitor index and a snapshot of all flags, and it is held
// until software acknowledges it with clear.
//
// Ports
//   clock          in   1        rising-edge clock for all logic
//   reset_n        in   1        synchronous active-low reset
//   enable         in   1        scanning enable; low forces IDLE
//   mon_block      in   NUM_MON  block flags from the per-process monitors
//   clear          in   1        single-cycle acknowledge of a report
//   deadlock       out  1        sticky deadlock report
//   deadlock_idx   out  IDX_W    monitor index that confirmed
//   deadlock_mask  out  NUM_MON  mon_block snapshot on the confirming cycle
//   scan_ptr       out  IDX_W    current scan pointer (debug)
//   event_cnt      out  8        confirmed-deadlock count, saturating at 255
// ----------------------------------------------------------------------------
module dhcp_client_deadlock_scan_ctrl #(
   parameter int NUM_MON     = 4,
   parameter int IDX_W       = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [NUM_MON-1:0] mon_block,
   input  logic               clear,
   output logic               deadlock,
   output logic [IDX_W-1:0]   deadlock_idx,
   output logic [NUM_MON-1:0] deadlock_mask,
   output logic [IDX_W-1:0]   scan_ptr,
   output logic [7:0]         event_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      CONFIRM = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic [IDX_W-1:0]     cand, cand_nx;
   logic [IDX_W-1:0]     scan_ptr_nx, idx_nx;
   logic [CNT_W-1:0]     hold_cnt, hold_nx;
   logic                 deadlock_nx;
   logic [NUM_MON-1:0]   mask_nx;
   logic [7:0]           event_nx;

   // Advance a monitor index with an explicit wrap at NUM_MON-1. A plain
   // modulo-2^IDX_W increment would not work when NUM_MON is not a power of two.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
      if (p == IDX_W'(NUM_MON - 1))
         return '0;
      else
         return p + IDX_W'(1);
   endfunction

   // Next-state and next-output logic. Every register's next value defaults to
   // its current value, so each branch lists only what changes. enable=0 wins
   // over the state decode and wipes everything except the event counter.
   // A clear is looked at only while already in REPORT. A clear that arrives on
   // the confirming cycle is therefore ignored.
   always_comb begin
      state_nx    = state;
      cand_nx     = cand;
      scan_ptr_nx = scan_ptr;
      hold_nx     = hold_cnt;
      deadlock_nx = deadlock;
      idx_nx      = deadlock_idx;
      mask_nx     = deadlock_mask;
      event_nx    = event_cnt;

      if (!enable) begin
         state_nx    = IDLE;
         cand_nx     = '0;
         scan_ptr_nx = '0;
         hold_nx     = '0;
         deadlock_nx = 1'b0;
         idx_nx      = '0;
         mask_nx     = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx    = SCAN;
               scan_ptr_nx = '0;
            end
            SCAN: begin
               if (mon_block[scan_ptr]) begin
                  state_nx = CONFIRM;
                  cand_nx  = scan_ptr;
                  hold_nx  = CNT_W'(1);
               end else begin
                  scan_ptr_nx = wrap_inc(scan_ptr);
               end
            end
            CONFIRM: begin
               if (mon_block[cand]) begin
                  if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     state_nx    = REPORT;
                     deadlock_nx = 1'b1;
                     idx_nx      = cand;
                     mask_nx     = mon_block;
                     hold_nx     = '0;
                     event_nx    = (event_cnt == 8'hFF) ? event_cnt : event_cnt + 8'd1;
                  end else begin
                     hold_nx = hold_cnt + CNT_W'(1);
                  end
               end else begin
                  state_nx    = SCAN;
                  scan_ptr_nx = wrap_inc(cand);
                  hold_nx     = '0;
               end
            end
            REPORT: begin
               if (clear) begin
                  state_nx    = SCAN;
                  scan_ptr_nx = wrap_inc(cand);
                  deadlock_nx = 1'b0;
                  idx_nx      = '0;
                  mask_nx     = '0;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   // State and output registers. Every output comes straight from a flop.
   // reset_n is sampled on the clock edge and overrides enable and clear.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         cand          <= '0;
         scan_ptr      <= '0;
         hold_cnt      <= '0;
         deadlock      <= 1'b0;
         deadlock_idx  <= '0;
         deadlock_mask <= '0;
         event_cnt     <= '0;
      end else begin
         state         <= state_nx;
         cand          <= cand_nx;
         scan_ptr      <= scan_ptr_nx;
         hold_cnt      <= hold_nx;
         deadlock      <= deadlock_nx;
         deadlock_idx  <= idx_nx;
         deadlock_mask <= mask_nx;
         event_cnt     <= event_nx;
      end
   end

endmodule

// File: tb/tb_dhcp_client_deadlock_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dhcp_client_deadlock_scan_ctrl
//
// Self-checking bench for dhcp_client_deadlock_scan_ctrl with NUM_MON=4 and
// HOLD_CYCLES=16. A table of {inputs, cycle count, expected outputs} rows walks
// through confirmation, a near-miss, a sticky report, wrap-around, a clear on
// the entry cycle and enable drops. Hand-written sequences then cover counter
// saturation and reset. Expected records go into a scoreboard queue when
// stimulus is applied, and they are popped when the outputs are sampled.
// ----------------------------------------------------------------------------
module tb_dhcp_client_deadlock_scan_ctrl;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic [3:0] mon_block;
   logic       clear;
   logic       deadlock;
   logic [1:0] deadlock_idx;
   logic [3:0] deadlock_mask;
   logic [1:0] scan_ptr;
   logic [7:0] event_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic [3:0] mon;
      logic       clr;
      int         cycles;
      logic       exp_dl;
      logic [1:0] exp_idx;
      logic [3:0] exp_mask;
      logic [7:0] exp_evt;
      logic [1:0] exp_ptr;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   dhcp_client_deadlock_scan_ctrl #(
      .NUM_MON(4), .IDX_W(2), .HOLD_CYCLES(16), .CNT_W(16)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .mon_block(mon_block),
      .clear(clear),
      .deadlock(deadlock),
      .deadlock_idx(deadlock_idx),
      .deadlock_mask(deadlock_mask),
      .scan_ptr(scan_ptr),
      .event_cnt(event_cnt)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges, then settle 1 unit so that sampling and driving
   // both happen well away from the edge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic cmp(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Drive one row's inputs for its cycle count and queue the row's expectation
   task automatic applyStimulus(input vec_t v);
      enable    = v.en;
      mon_block = v.mon;
      clear     = v.clr;
      step(v.cycles);
      exp_q.push_back(v);
   endtask

   // Pop the oldest expectation and compare it against the sampled outputs
   task automatic checkOutput(input string tag);
      vec_t e;
      if (exp_q.size() == 0) begin
         cmp({tag, ".queue_empty"}, 1, 0);
         return;
      end
      e = exp_q.pop_front();
      cmp({tag, ".deadlock"}, int'(deadlock),      int'(e.exp_dl));
      cmp({tag, ".idx"},      int'(deadlock_idx),  int'(e.exp_idx));
      cmp({tag, ".mask"},     int'(deadlock_mask), int'(e.exp_mask));
      cmp({tag, ".evt"},      int'(event_cnt),     int'(e.exp_evt));
      cmp({tag, ".ptr"},      int'(scan_ptr),      int'(e.exp_ptr));
   endtask

   initial begin
      vec_t v;
      int   evt_model;
      int   waited;

      // Each row is {en, mon, clr, cycles, dl, idx, mask, evt, ptr}. The rows
      // run back to back, and each row's outputs are sampled after its last edge.
      // Single steady flag on monitor 2. It confirms 16 edges after ptr reaches 2.
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd0});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   2, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd2});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,  15, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd2});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   1, 1'b1, 2'd2, 4'b0100, 8'd1, 2'd2});
      // The report is sticky for 100 cycles with flags low. A clear resumes at idx+1.
      vecs.push_back('{1'b1, 4'b0000, 1'b0, 100, 1'b1, 2'd2, 4'b0100, 8'd1, 2'd2});
      vecs.push_back('{1'b1, 4'b0000, 1'b1,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd3});
      vecs.push_back('{1'b1, 4'b0000, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd0});
      // Monitor 1 is high for only 15 samples, then drops. Scanning resumes at 2.
      vecs.push_back('{1'b1, 4'b0010, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd1});
      vecs.push_back('{1'b1, 4'b0010, 1'b0,  15, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd1});
      vecs.push_back('{1'b1, 4'b0000, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd2});
      vecs.push_back('{1'b1, 4'b0000, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd3});
      // Flags 1001 appear while ptr is 3. Index 3 confirms, then the next report wraps to 0.
      vecs.push_back('{1'b1, 4'b1001, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd1, 2'd3});
      vecs.push_back('{1'b1, 4'b1001, 1'b0,  15, 1'b1, 2'd3, 4'b1001, 8'd2, 2'd3});
      vecs.push_back('{1'b1, 4'b1001, 1'b1,   1, 1'b0, 2'd0, 4'b0000, 8'd2, 2'd0});
      vecs.push_back('{1'b1, 4'b1001, 1'b0,  15, 1'b0, 2'd0, 4'b0000, 8'd2, 2'd0});
      // A clear on the confirming cycle is ignored. A clear one cycle later is honoured.
      vecs.push_back('{1'b1, 4'b1001, 1'b1,   1, 1'b1, 2'd0, 4'b1001, 8'd3, 2'd0});
      vecs.push_back('{1'b1, 4'b1001, 1'b1,   1, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd1});
      // A clear while scanning has no effect.
      vecs.push_back('{1'b1, 4'b0000, 1'b1,   1, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd2});
      // enable drops mid-CONFIRM. Re-enabling restarts at ptr 0 with a full hold.
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd2});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   5, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd2});
      vecs.push_back('{1'b0, 4'b0100, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd0});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd0});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   2, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd2});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,  15, 1'b0, 2'd0, 4'b0000, 8'd3, 2'd2});
      vecs.push_back('{1'b1, 4'b0100, 1'b0,   1, 1'b1, 2'd2, 4'b0100, 8'd4, 2'd2});
      // enable drops during REPORT. Only event_cnt survives.
      vecs.push_back('{1'b0, 4'b0100, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd4, 2'd0});
      vecs.push_back('{1'b0, 4'b0100, 1'b0,   3, 1'b0, 2'd0, 4'b0000, 8'd4, 2'd0});
      vecs.push_back('{1'b1, 4'b0000, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd4, 2'd0});
      vecs.push_back('{1'b1, 4'b0000, 1'b0,   1, 1'b0, 2'd0, 4'b0000, 8'd4, 2'd1});

      // Reset with enable low, then check that every output is zero
      reset_n   = 1'b0;
      enable    = 1'b0;
      mon_block = 4'b0000;
      clear     = 1'b0;
      step(2);
      exp_q.push_back('{1'b0, 4'b0000, 1'b0, 0, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd0});
      checkOutput("reset");
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d", i));
      end

      // Saturation: with every flag high, each clear leads to a report at the next
      // index. The counter continues from 4 and must stop at 255.
      $display("[TB] saturation sequence");
      evt_model = 4;
      for (int k = 0; k < 260; k++) begin
         enable    = 1'b1;
         mon_block = 4'b1111;
         clear     = 1'b0;
         waited    = 0;
         while (!deadlock && waited < 40) begin
            step(1);
            waited++;
         end
         evt_model = (evt_model == 255) ? 255 : evt_model + 1;
         v = '{1'b1, 4'b1111, 1'b0, 0, 1'b1, 2'((1 + k) % 4), 4'b1111,
               8'(evt_model), 2'((1 + k) % 4)};
         exp_q.push_back(v);
         checkOutput($sformatf("sat%0d", k));
         clear = 1'b1;
         step(1);
         clear = 1'b0;
      end

      // A one-cycle reset mid-activity dominates enable and zeroes every output
      enable    = 1'b1;
      mon_block = 4'b1111;
      reset_n   = 1'b0;
      step(1);
      exp_q.push_back('{1'b1, 4'b1111, 1'b0, 0, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd0});
      checkOutput("reset2");
      reset_n   = 1'b1;
      mon_block = 4'b0000;
      step(1);
      exp_q.push_back('{1'b1, 4'b0000, 1'b0, 0, 1'b0, 2'd0, 4'b0000, 8'd0, 2'd0});
      checkOutput("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
